alu_sequencer: RTL
==================

# alu_sequencer

Drives the 8-bit ALU's operation strobes, operand inputs and output enables for one operation at a time, then captures the result and N/V/Z/C status into registered outputs. Sits between the instruction decoder (which issues a 4-bit operation code and operands over a req/ready handshake) and the ALU. It maps 6502 operations onto the ALU's primitive set: ASL and ROL run as A+A, INC and DEC as additions, and CMP as a subtract whose result is discarded. It holds the processor's N, V, Z and C flags and reads D from the status logic.

## Interface
- No parameters.
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high
- req  in  1  operation request; sampled only while ready=1
- op  in  4  operation code; see Operation
- opa  in  8  operand A (accumulator/memory)
- opb  in  8  operand B
- d_flag  in  1  decimal mode bit from status register
- flag_ld  in  1  write {n,v,z,c}_flag from flag_din; honoured only while ready=1
- flag_din  in  4  {N,V,Z,C}
- ready  out  1  high in IDLE
- done  out  1  one-cycle pulse: result/flags updated
- err  out  1  one-cycle pulse with done for illegal op
- result  out  8  last written result
- n_flag, v_flag, z_flag, c_flag  out  1 each  status flags
- alu_a, alu_b  out  8  ALU operands
- alu_cin, alu_sums, alu_subs, alu_ands, alu_eors, alu_ors, alu_shftr, alu_shftcr, alu_decen, alu_adloa, alu_sboa  out  1  ALU controls
- alu_sb  in  8  ALU SB bus
- alu_cout, alu_zero, alu_overflow, alu_neg  in  1  ALU status

## Operation
- States: IDLE → EXEC → READ → IDLE. Illegal ops go IDLE → IDLE.
- IDLE with req=1:
  - Latch op.
  - Latch alu_a/alu_b per the op table.
  - Go to EXEC.
- EXEC:
  - Assert exactly the op's strobe(s) and alu_cin.
  - At the closing edge, capture the flags listed for the op from alu_neg/alu_overflow/alu_zero/alu_cout.
  - Flags not listed are held.
- READ:
  - Assert alu_sboa only.
  - At the closing edge, load result from alu_sb (except CMP) and set done=1 for the following cycle.
  - Go to IDLE.
- All strobes are 0 outside EXEC. alu_sboa is 1 only in READ. alu_adloa is always 0.
- alu_a/alu_b hold their latched values until the next accept.
- alu_cin uses c_flag as it stands during EXEC.
- Op table: strobe, a, b, cin, flags updated.
  - 0 ADC: sums, opa, opb, C, NVZC. alu_decen = d_flag.
  - 1 SBC: subs, opa, opb, C, NVZC. alu_decen = d_flag.
  - 2 AND: ands, opa, opb, -, NZ
  - 3 ORA: ors, opa, opb, -, NZ
  - 4 EOR: eors, opa, opb, -, NZ
  - 5 ASL: sums, opa, opa, 0, NZC
  - 6 ROL: sums, opa, opa, C, NZC
  - 7 LSR: shftr, opa, -, -, NZC
  - 8 ROR: shftcr, opa, -, C, NZC
  - 9 CMP: subs, opa, opb, 1, NZC. alu_decen = 0. result not written.
  - 10 INC: sums, opa, 0x00, 1, NZ
  - 11 DEC: sums, opa, 0xFF, 0, NZ
  - alu_decen = 0 for every op except ADC/SBC.
- Illegal ops 12–15:
  - Accepted from IDLE, no ALU activity.
  - done=1 and err=1 in the next cycle.
  - result and flags unchanged.
  - State stays IDLE.
- flag_ld in IDLE writes all four flags at the edge.
  - If accepted together with req, the op sees the new C.
  - flag_ld outside IDLE is ignored.
- Reset (any state, asynchronous):
  - state=IDLE, ready=1.
  - done=0, err=0, result=0x00, all flags 0.
  - alu_a/alu_b=0x00, all ALU controls 0.
  - An in-flight op is discarded and no done pulse follows.

## Timing
- Accept at edge k (req=1, ready=1). EXEC in cycle k+1, READ in k+2. done, result and flags are valid in cycle k+3.
- Flags are visible from cycle k+2, result from cycle k+3.
- ready=0 in cycles k+1 and k+2. ready=1 in k+3, so back-to-back ops give one op per 3 cycles.
- done and err are registered and last exactly one cycle.
- req is ignored while ready=0; there is no queueing.

## Test plan
- ADC opa=0x50, opb=0x50, C=0, D=0 → alu_sums high only in EXEC; result 0xA0, N=1 V=1 Z=0 C=0; done exactly 3 cycles after the accept edge.
- ASL opa=0x81 → alu_a=alu_b=0x81, cin=0; result 0x02, C=1 N=0 Z=0. Then ROL opa=0x40 back-to-back → result 0x81, C=0, N=1.
- Preload result=0x77 via AND 0x77&0xFF. Then CMP 0x10 vs 0x10 → Z=1 C=1 N=0, result stays 0x77, done pulses.
- flag_ld with flag_din=4'b0001 together with req for ROR opa=0x02 → cin=1 during EXEC; result 0x81, C=0, N=1.
- op=13 → done and err pulse in the next cycle, no strobes asserted, result/flags unchanged, ready stays 1. ADC 0x15+0x23 with d_flag=1 → alu_decen high in EXEC, result 0x38.
- Accept an INC, then assert reset during READ → all outputs take their reset values immediately; no done pulse; after release, DEC opa=0x00 → result 0xFF, N=1 Z=0.

Source files
------------

// File: rtl/alu_sequencer.sv
// Sequences one 6502-style operation through the 8-bit ALU per request:
// latch operands, pulse the op's strobes, capture status, then read the result.
module alu_sequencer (
    input  logic       clk,
    input  logic       reset,
    input  logic       req,
    input  logic [3:0] op,
    input  logic [7:0] opa,
    input  logic [7:0] opb,
    input  logic       d_flag,
    input  logic       flag_ld,
    input  logic [3:0] flag_din,
    output logic       ready,
    output logic       done,
    output logic       err,
    output logic [7:0] result,
    output logic       n_flag,
    output logic       v_flag,
    output logic       z_flag,
    output logic       c_flag,
    output logic [7:0] alu_a,
    output logic [7:0] alu_b,
    output logic       alu_cin,
    output logic       alu_sums,
    output logic       alu_subs,
    output logic       alu_ands,
    output logic       alu_eors,
    output logic       alu_ors,
    output logic       alu_shftr,
    output logic       alu_shftcr,
    output logic       alu_decen,
    output logic       alu_adloa,
    output logic       alu_sboa,
    input  logic [7:0] alu_sb,
    input  logic       alu_cout,
    input  logic       alu_zero,
    input  logic       alu_overflow,
    input  logic       alu_neg
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_READ = 2'd2
    } state_t;

    typedef struct packed {
        logic       legal;
        logic [6:0] strobe;
        logic       cin;
        logic       decen;
        logic [1:0] bsel;
    } op_ctl_t;

    localparam logic [1:0] B_OPB  = 2'd0;
    localparam logic [1:0] B_OPA  = 2'd1;
    localparam logic [1:0] B_ZERO = 2'd2;
    localparam logic [1:0] B_ONES = 2'd3;

    // Strobe vector order: {sums, subs, ands, eors, ors, shftr, shftcr}
    localparam logic [6:0] ST_SUMS   = 7'b1000000;
    localparam logic [6:0] ST_SUBS   = 7'b0100000;
    localparam logic [6:0] ST_ANDS   = 7'b0010000;
    localparam logic [6:0] ST_EORS   = 7'b0001000;
    localparam logic [6:0] ST_ORS    = 7'b0000100;
    localparam logic [6:0] ST_SHFTR  = 7'b0000010;
    localparam logic [6:0] ST_SHFTCR = 7'b0000001;

    localparam logic [3:0] OP_CMP = 4'd9;

    function automatic op_ctl_t decode_op(input logic [3:0] code, input logic c, input logic d);
        op_ctl_t ctl;
        ctl.legal  = 1'b1;
        ctl.strobe = 7'b0000000;
        ctl.cin    = 1'b0;
        ctl.decen  = 1'b0;
        ctl.bsel   = B_OPB;
        case (code)
            4'd0:  begin ctl.strobe = ST_SUMS;   ctl.cin = c;    ctl.decen = d; end
            4'd1:  begin ctl.strobe = ST_SUBS;   ctl.cin = c;    ctl.decen = d; end
            4'd2:  begin ctl.strobe = ST_ANDS; end
            4'd3:  begin ctl.strobe = ST_ORS; end
            4'd4:  begin ctl.strobe = ST_EORS; end
            4'd5:  begin ctl.strobe = ST_SUMS;   ctl.bsel = B_OPA; end
            4'd6:  begin ctl.strobe = ST_SUMS;   ctl.bsel = B_OPA; ctl.cin = c; end
            4'd7:  begin ctl.strobe = ST_SHFTR;  ctl.bsel = B_ZERO; end
            4'd8:  begin ctl.strobe = ST_SHFTCR; ctl.bsel = B_ZERO; ctl.cin = c; end
            4'd9:  begin ctl.strobe = ST_SUBS;   ctl.cin = 1'b1; end
            4'd10: begin ctl.strobe = ST_SUMS;   ctl.bsel = B_ZERO; ctl.cin = 1'b1; end
            4'd11: begin ctl.strobe = ST_SUMS;   ctl.bsel = B_ONES; end
            default: ctl.legal = 1'b0;
        endcase
        return ctl;
    endfunction

    // Which of {N,V,Z,C} the op updates when its EXEC cycle closes.
    function automatic logic [3:0] flag_mask(input logic [3:0] code);
        logic [3:0] m;
        case (code)
            4'd0, 4'd1:                   m = 4'b1111;
            4'd2, 4'd3, 4'd4, 4'd10, 4'd11: m = 4'b1010;
            4'd5, 4'd6, 4'd7, 4'd8, 4'd9:   m = 4'b1011;
            default:                      m = 4'b0000;
        endcase
        return m;
    endfunction

    state_t     state_q, state_d;
    logic [3:0] op_q, op_d;
    logic       ready_q, ready_d;
    logic       done_q, done_d;
    logic       err_q, err_d;
    logic [7:0] result_q, result_d;
    logic [3:0] flags_q, flags_d;
    logic [7:0] alu_a_q, alu_a_d;
    logic [7:0] alu_b_q, alu_b_d;
    logic [6:0] strobe_q, strobe_d;
    logic       cin_q, cin_d;
    logic       decen_q, decen_d;
    logic       sboa_q, sboa_d;

    logic       c_new_s;
    logic [3:0] mask_s;
    logic [3:0] alu_flags_s;
    op_ctl_t    acc_ctl_s;

    assign alu_flags_s = {alu_neg, alu_overflow, alu_zero, alu_cout};

    // Next-state, operand latching, flag capture and result load.
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        result_d  = result_q;
        flags_d   = flags_q;
        alu_a_d   = alu_a_q;
        alu_b_d   = alu_b_q;
        strobe_d  = 7'b0000000;
        cin_d     = 1'b0;
        decen_d   = 1'b0;
        sboa_d    = 1'b0;
        mask_s    = flag_mask(op_q);

        // An op accepted alongside flag_ld must see the freshly written carry.
        if (flag_ld) begin
            c_new_s = flag_din[0];
        end else begin
            c_new_s = flags_q[0];
        end
        acc_ctl_s = decode_op(op, c_new_s, d_flag);

        case (state_q)
            S_IDLE: begin
                if (flag_ld) begin
                    flags_d = flag_din;
                end else begin
                    flags_d = flags_q;
                end
                if (req) begin
                    if (acc_ctl_s.legal) begin
                        op_d     = op;
                        alu_a_d  = opa;
                        strobe_d = acc_ctl_s.strobe;
                        cin_d    = acc_ctl_s.cin;
                        decen_d  = acc_ctl_s.decen;
                        state_d  = S_EXEC;
                        case (acc_ctl_s.bsel)
                            B_OPB:   alu_b_d = opb;
                            B_OPA:   alu_b_d = opa;
                            B_ZERO:  alu_b_d = 8'h00;
                            B_ONES:  alu_b_d = 8'hFF;
                            default: alu_b_d = 8'h00;
                        endcase
                    end else begin
                        done_d = 1'b1;
                        err_d  = 1'b1;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_EXEC: begin
                flags_d = (alu_flags_s & mask_s) | (flags_q & ~mask_s);
                sboa_d  = 1'b1;
                state_d = S_READ;
            end
            S_READ: begin
                if (op_q != OP_CMP) begin
                    result_d = alu_sb;
                end else begin
                    result_d = result_q;
                end
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        ready_d = (state_d == S_IDLE);
    end

    // State and registered outputs; reset discards any in-flight op.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            op_q     <= 4'd0;
            ready_q  <= 1'b1;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            result_q <= 8'h00;
            flags_q  <= 4'b0000;
            alu_a_q  <= 8'h00;
            alu_b_q  <= 8'h00;
            strobe_q <= 7'b0000000;
            cin_q    <= 1'b0;
            decen_q  <= 1'b0;
            sboa_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            ready_q  <= ready_d;
            done_q   <= done_d;
            err_q    <= err_d;
            result_q <= result_d;
            flags_q  <= flags_d;
            alu_a_q  <= alu_a_d;
            alu_b_q  <= alu_b_d;
            strobe_q <= strobe_d;
            cin_q    <= cin_d;
            decen_q  <= decen_d;
            sboa_q   <= sboa_d;
        end
    end

    assign ready      = ready_q;
    assign done       = done_q;
    assign err        = err_q;
    assign result     = result_q;
    assign n_flag     = flags_q[3];
    assign v_flag     = flags_q[2];
    assign z_flag     = flags_q[1];
    assign c_flag     = flags_q[0];
    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_cin    = cin_q;
    assign alu_sums   = strobe_q[6];
    assign alu_subs   = strobe_q[5];
    assign alu_ands   = strobe_q[4];
    assign alu_eors   = strobe_q[3];
    assign alu_ors    = strobe_q[2];
    assign alu_shftr  = strobe_q[1];
    assign alu_shftcr = strobe_q[0];
    assign alu_decen  = decen_q;
    assign alu_adloa  = 1'b0;
    assign alu_sboa   = sboa_q;

endmodule
